a5_burst_decipher: RTL and testbench

Receive-side A5/1 burst processor. It takes a 64-bit session key, a 22-bit frame number and one 114-bit ciphered burst. It then runs key setup, frame mixing and 100 discard cycles on its own three LFSRs, and returns the 114-bit deciphered burst. It sits between the burst demodulator and the channel decoder and is the counterpart of the transmit-side cipher stage. XOR keystream is symmetric, so the same block also enciphers.

---
 rtl/a5_burst_decipher_if.sv | 17 +
 rtl/a5_burst_decipher.sv | 132 +++++++++++++
 tb/tb_a5_burst_decipher.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/a5_burst_decipher_if.sv
// Burst request/response bundle for the A5/1 burst decipher.
interface a5_burst_decipher_if #(
  parameter int KEYLEN   = 64,
  parameter int FRAMELEN = 22,
  parameter int CHUNKLEN = 114
);
  logic                start;
  logic [KEYLEN-1:0]   key;
  logic [FRAMELEN-1:0] frame;
  logic [CHUNKLEN-1:0] in;
  logic                busy;
  logic                done;
  logic [CHUNKLEN-1:0] out;

  modport master (output start, key, frame, in, input busy, done, out);
  modport slave  (input start, key, frame, in, output busy, done, out);
endinterface

// File: rtl/a5_burst_decipher.sv
// A5/1 burst processor: key setup, frame mixing, discard, then XOR of one
// burst with the generated keystream. The same block enciphers.
module a5_burst_decipher #(
  parameter int                 REG1LEN  = 19,
  parameter int                 REG2LEN  = 22,
  parameter int                 REG3LEN  = 23,
  parameter logic [REG1LEN-1:0] MASK1    = 19'h72000,
  parameter logic [REG2LEN-1:0] MASK2    = 22'h300000,
  parameter logic [REG3LEN-1:0] MASK3    = 23'h700080,
  parameter int                 SYNCBIT1 = 8,
  parameter int                 SYNCBIT2 = 10,
  parameter int                 SYNCBIT3 = 10,
  parameter int                 KEYLEN   = 64,
  parameter int                 FRAMELEN = 22,
  parameter int                 DISCARD  = 100,
  parameter int                 CHUNKLEN = 114
) (
  input logic               clock,
  input logic               reset_n,
  a5_burst_decipher_if.slave bus
);

  localparam int CW  = $clog2(CHUNKLEN);
  localparam int KIW = $clog2(KEYLEN);
  localparam int FIW = $clog2(FRAMELEN);
  localparam logic [CW-1:0] KEY_LAST   = CW'(KEYLEN - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAMELEN - 1);
  localparam logic [CW-1:0] MIX_LAST   = CW'(DISCARD - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(CHUNKLEN - 1);

  typedef enum logic [2:0] {IDLE, KEY, FRAME, MIX, RUN, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [REG1LEN-1:0]  r1, r1_nx;
  logic [REG2LEN-1:0]  r2, r2_nx;
  logic [REG3LEN-1:0]  r3, r3_nx;
  logic [KEYLEN-1:0]   key_l;
  logic [FRAMELEN-1:0] frame_l;
  logic [CHUNKLEN-1:0] in_l, acc, out_q;
  logic                busy_q, done_q;
  logic                inj, m, st1, st2, st3, z;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

  // Next register values for the current phase; z uses post-step MSBs.
  always_comb begin
    inj = 1'b0;
    if (state == KEY)        inj = key_l[cnt[KIW-1:0]];
    else if (state == FRAME) inj = frame_l[cnt[FIW-1:0]];
    m = (r1[SYNCBIT1] & r2[SYNCBIT2]) | (r1[SYNCBIT1] & r3[SYNCBIT3]) |
        (r2[SYNCBIT2] & r3[SYNCBIT3]);
    if (state == MIX || state == RUN) begin
      st1 = (r1[SYNCBIT1] == m);
      st2 = (r2[SYNCBIT2] == m);
      st3 = (r3[SYNCBIT3] == m);
    end else begin
      st1 = 1'b1;
      st2 = 1'b1;
      st3 = 1'b1;
    end
    r1_nx = st1 ? {r1[REG1LEN-2:0], ^(r1 & MASK1) ^ inj} : r1;
    r2_nx = st2 ? {r2[REG2LEN-2:0], ^(r2 & MASK2) ^ inj} : r2;
    r3_nx = st3 ? {r3[REG3LEN-2:0], ^(r3 & MASK3) ^ inj} : r3;
    z = r1_nx[REG1LEN-1] ^ r2_nx[REG2LEN-1] ^ r3_nx[REG3LEN-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      r1      <= '0;
      r2      <= '0;
      r3      <= '0;
      key_l   <= '0;
      frame_l <= '0;
      in_l    <= '0;
      acc     <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= bus.start;
          if (bus.start) begin
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
            key_l   <= bus.key;
            frame_l <= bus.frame;
            in_l    <= bus.in;
            cnt     <= '0;
            state   <= KEY;
          end
        end
        KEY: begin
          r1 <= r1_nx; r2 <= r2_nx; r3 <= r3_nx;
          if (cnt == KEY_LAST) begin cnt <= '0; state <= FRAME; end
          else cnt <= cnt + 1'b1;
        end
        FRAME: begin
          r1 <= r1_nx; r2 <= r2_nx; r3 <= r3_nx;
          if (cnt == FRAME_LAST) begin cnt <= '0; state <= MIX; end
          else cnt <= cnt + 1'b1;
        end
        MIX: begin
          r1 <= r1_nx; r2 <= r2_nx; r3 <= r3_nx;
          if (cnt == MIX_LAST) begin cnt <= '0; state <= RUN; end
          else cnt <= cnt + 1'b1;
        end
        RUN: begin
          r1 <= r1_nx; r2 <= r2_nx; r3 <= r3_nx;
          acc[cnt] <= in_l[cnt] ^ z;
          if (cnt == RUN_LAST) begin cnt <= '0; state <= DONE; end
          else cnt <= cnt + 1'b1;
        end
        DONE: begin
          out_q  <= acc;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a5_burst_decipher.sv
// Scoreboard bench for a5_burst_decipher: stimulus pushes expected bursts,
// a negedge monitor pops and compares on every done pulse.
module tb_a5_burst_decipher;

  logic clock;
  logic reset_n;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [113:0] exp_q[$];
  logic [63:0]  trc [0:299];

  a5_burst_decipher_if bus ();

  a5_burst_decipher dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_val(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [113:0] got, input logic [113:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference A5/1 with explicit tap bits; records register state after every step.
  task automatic model(input logic [63:0] k, input logic [21:0] f, output logic [113:0] ks);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic [63:0] kk;
    logic [21:0] ff;
    logic        bi, mj;
    logic [8:0]  t;
    a = '0; b = '0; c = '0; kk = k; ff = f; ks = '0; t = '0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) begin bi = kk[0]; kk = kk >> 1; end
      else begin bi = ff[0]; ff = ff >> 1; end
      a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ bi};
      b = {b[20:0], b[21] ^ b[20] ^ bi};
      c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ bi};
      trc[t] = {a, b, c};
      t = t + 1'b1;
    end
    for (int i = 0; i < 214; i++) begin
      mj = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
      if (a[8] == mj)  a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
      if (b[10] == mj) b = {b[20:0], b[21] ^ b[20]};
      if (c[10] == mj) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
      trc[t] = {a, b, c};
      t = t + 1'b1;
      if (i >= 100) ks = {a[18] ^ b[21] ^ c[22], ks[113:1]};
    end
  endtask

  function automatic logic [113:0] rnd114();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[113:0];
  endfunction

  // mode: 0 plain, 1 stray start pulses, 2 scrambled inputs, 3 register trace, 4 reset at n=200
  task automatic run_burst(input logic [63:0] k, input logic [21:0] f, input logic [113:0] d,
                           input int mode, output logic [113:0] got);
    logic [113:0] ks;
    int n, busy_cnt, mism;
    bit seen;
    model(k, f, ks);
    @(negedge clock);
    bus.key = k; bus.frame = f; bus.in = d; bus.start = 1'b1;
    if (mode != 4) exp_q.push_back(d ^ ks);
    @(posedge clock);
    busy_cnt = 0; mism = 0; got = '0; seen = 1'b0;
    for (n = 0; n <= 400; n++) begin
      @(negedge clock);
      bus.start = (mode == 1) && (n == 5 || n == 100 || n == 300);
      if (bus.start) begin bus.key = ~k; bus.frame = ~f; bus.in = ~d; end
      if (mode == 2) begin
        bus.key = {$urandom, $urandom}; bus.frame = 22'($urandom); bus.in = rnd114();
      end
      if (mode == 3 && n >= 1 && n <= 300)
        if ({dut.r1, dut.r2, dut.r3} !== trc[9'(n - 1)]) mism++;
      if (mode == 4 && n == 200) begin
        reset_n = 1'b0;
        #1;
        chk_val("midrun_reset_busy", int'(bus.busy), 0);
        chk_val("midrun_reset_done", int'(bus.done), 0);
        chk_bus("midrun_reset_out", bus.out, '0);
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin seen = 1'b1; break; end
    end
    chk_val("done_seen", int'(seen), 1);
    chk_val("done_latency", n, 301);
    chk_val("busy_cycles", busy_cnt, 301);
    got = bus.out;
    @(negedge clock);
    chk_val("done_single_pulse", int'(bus.done), 0);
    chk_val("busy_idle", int'(bus.busy), 0);
    if (mode == 3) chk_val("reg_trace_mismatches", mism, 0);
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got out %h, expected no done", bus.out);
      end else begin
        chk_bus("sb_out", bus.out, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [63:0]  k;
    logic [21:0]  f;
    logic [113:0] d, d2, g1, g2, ks;
    int n, ndone, t1, t2;

    reset_n = 1'b0;
    bus.start = 1'b0; bus.key = '0; bus.frame = '0; bus.in = '0;
    #3;
    chk_val("reset_busy", int'(bus.busy), 0);
    chk_val("reset_done", int'(bus.done), 0);
    chk_bus("reset_out", bus.out, '0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // All-zero key/frame keeps the registers at zero: out must equal in.
    d = {57{2'b10}};
    run_burst('0, '0, d, 0, g1);
    chk_bus("zero_key_passthru", g1, d);

    run_burst(64'h1223456789ABCDEF, 22'h134, '0, 3, g1);

    k = {$urandom, $urandom}; f = 22'($urandom); d = rnd114();
    run_burst(k, f, d, 0, g1);
    run_burst(k, f, g1, 0, g2);
    chk_bus("symmetry", g2, d);

    k = {$urandom, $urandom}; f = 22'($urandom); d = rnd114();
    run_burst(k, f, d, 1, g1);

    k = {$urandom, $urandom}; f = 22'($urandom); d = rnd114();
    run_burst(k, f, d, 0, g1);
    run_burst(k, f, d, 2, g2);
    chk_bus("scramble_vs_stable", g2, g1);

    run_burst(k, f, d, 4, g1);
    d2 = rnd114();
    run_burst(k, f, d2, 0, g1);

    // Held start: two back-to-back bursts with a 302-cycle period.
    k = {$urandom, $urandom}; f = 22'($urandom); d = rnd114(); d2 = rnd114();
    model(k, f, ks);
    @(negedge clock);
    bus.key = k; bus.frame = f; bus.in = d; bus.start = 1'b1;
    exp_q.push_back(d ^ ks);
    @(posedge clock);
    ndone = 0; t1 = -1; t2 = -1;
    for (n = 0; n <= 800; n++) begin
      @(negedge clock);
      if (n == 0) begin bus.in = d2; exp_q.push_back(d2 ^ ks); end
      if (n == 302) chk_val("held_busy_reaccept", int'(bus.busy), 1);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) t1 = n;
        else begin t2 = n; bus.start = 1'b0; break; end
      end
    end
    bus.start = 1'b0;
    chk_val("held_done1_time", t1, 301);
    chk_val("held_done2_time", t2, 603);
    @(negedge clock);
    chk_val("held_idle_busy", int'(bus.busy), 0);

    repeat (5) @(negedge clock);
    chk_val("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
